serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial (STEP bits per cycle) adder/subtractor with a registered carry
// between slices; results, carry-out and overflow publish on entry to DONE.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;

  logic [STEP-1:0]  a_sl;
  logic [STEP-1:0]  b_sl;
  logic [STEP-1:0]  s_sl;
  logic             c;
  logic             c_msb;
  logic             c_out;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  // Full-adder chain over the current slice; c_msb ends as the carry into the
  // slice's top bit, which on the last slice is the carry into the word MSB.
  always_comb begin
    a_sl     = a_r[int'(cnt) * STEP +: STEP];
    b_sl     = b_r[int'(cnt) * STEP +: STEP] ^ {STEP{sub_r}};
    s_sl     = '0;
    c        = carry_r;
    c_msb    = carry_r;
    for (int i = 0; i < STEP; i++) begin
      c_msb   = c;
      s_sl[i] = a_sl[i] ^ b_sl[i] ^ c;
      c       = (a_sl[i] & b_sl[i]) | (c & (a_sl[i] ^ b_sl[i]));
    end
    c_out    = c;
    acc_next = acc;
    acc_next[int'(cnt) * STEP +: STEP] = s_sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            sub_r   <= sub;
            // Subtraction is a + ~b + 1, so the incoming carry replaces cin.
            carry_r <= sub ? 1'b1 : cin;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_r <= c_out;
          if (last) begin
            sum   <= acc_next;
            cout  <= c_out;
            ovf   <= c_msb ^ c_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 16/16) sharing
// operand inputs, each with its own start; expectations come from a scoreboard.
module tb_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  st;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin_in;
  logic        sub_in;
  logic [2:0]  busy_o;
  logic [2:0]  done_o;
  logic [2:0]  cout_o;
  logic [2:0]  ovf_o;
  logic [7:0]  s0;
  logic [7:0]  s1;
  logic [15:0] s2;
  logic [15:0] sum_o [3];

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  int   wd[3] = '{8, 8, 16};
  int   nn[3] = '{8, 2, 1};

  serial_adder #(.WIDTH(8), .STEP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy_o[0]), .done(done_o[0]),
    .sum(s0), .cout(cout_o[0]), .ovf(ovf_o[0]));

  serial_adder #(.WIDTH(8), .STEP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(a_in[7:0]), .b(b_in[7:0]),
    .cin(cin_in), .sub(sub_in), .busy(busy_o[1]), .done(done_o[1]),
    .sum(s1), .cout(cout_o[1]), .ovf(ovf_o[1]));

  serial_adder #(.WIDTH(16), .STEP(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(a_in), .b(b_in),
    .cin(cin_in), .sub(sub_in), .busy(busy_o[2]), .done(done_o[2]),
    .sum(s2), .cout(cout_o[2]), .ovf(ovf_o[2]));

  assign sum_o[0] = {8'h00, s0};
  assign sum_o[1] = {8'h00, s1};
  assign sum_o[2] = s2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: overflow from operand/result signs rather than internal carries.
  function automatic exp_t ref_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                     input logic ci, input logic sb);
    logic [16:0] mask;
    logic [15:0] aa;
    logic [15:0] bb;
    logic [16:0] full;
    exp_t        e;
    mask = (17'd1 << w) - 17'd1;
    aa   = av & mask[15:0];
    bb   = (sb ? ~bv : bv) & mask[15:0];
    full = {1'b0, aa} + {1'b0, bb} + {16'd0, (sb ? 1'b1 : ci)};
    e.sum  = full[15:0] & mask[15:0];
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return e;
  endfunction

  function automatic exp_t observed(input int u);
    exp_t o;
    o.sum  = sum_o[u];
    o.cout = cout_o[u];
    o.ovf  = ovf_o[u];
    return o;
  endfunction

  // Drives start for one capture edge, then scrambles the operand inputs.
  task automatic issue(input int u, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb);
    a_in = av; b_in = bv; cin_in = ci; sub_in = sb; st[u] = 1'b1;
    q.push_back(ref_model(wd[u], av, bv, ci, sb));
    @(posedge clk); #1;
    st[u] = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom);
    cin_in = 1'($urandom); sub_in = 1'($urandom);
  endtask

  task automatic wait_done(input int u, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (done_o[u] !== 1'b1 && cyc < 60);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; st = '0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    #3;
    for (int u = 0; u < 3; u++) begin
      n_vec++;
      if ({busy_o[u], done_o[u], sum_o[u], cout_o[u], ovf_o[u]} !== 20'd0) begin
        n_err++;
        $display("FAIL reset_state u=%0d got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                 u, busy_o[u], done_o[u], sum_o[u], cout_o[u], ovf_o[u]);
      end
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] av [5] = '{16'hFF, 16'h7F, 16'h80, 16'h05, 16'h05};
    logic [15:0] bv [5] = '{16'h01, 16'h01, 16'hFF, 16'h07, 16'h07};
    logic        cv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        sv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t prev, e;
    int   cyc;
    for (int i = 0; i < 5; i++) begin
      prev = observed(0);
      issue(0, av[i], bv[i], cv[i], sv[i]);
      n_vec++;
      if (busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL dir_busy_start #%0d got busy=%b done=%b want busy=1 done=0",
                 i, busy_o[0], done_o[0]);
      end
      n_vec++;
      if (observed(0) !== prev) begin
        n_err++;
        $display("FAIL dir_hold_run #%0d got %h want %h", i, observed(0), prev);
      end
      wait_done(0, cyc);
      e = q.pop_front();
      n_vec++;
      if (cyc !== nn[0]) begin
        n_err++;
        $display("FAIL dir_latency #%0d got %0d want %0d", i, cyc, nn[0]);
      end
      n_vec++;
      if (observed(0) !== e) begin
        n_err++;
        $display("FAIL dir_result #%0d got sum/cout/ovf=%h want %h", i, observed(0), e);
      end
      @(posedge clk); #1;
      n_vec++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || observed(0) !== e) begin
        n_err++;
        $display("FAIL dir_after_done #%0d got done=%b busy=%b res=%h want 0 0 %h",
                 i, done_o[0], busy_o[0], observed(0), e);
      end
    end
  endtask

  task automatic test_mid_start;
    exp_t e;
    int   cyc, pulses;
    issue(0, 16'h3C, 16'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        st[0] = 1'b1; a_in = 16'hAA; b_in = 16'hF0; cin_in = 1'b0; sub_in = 1'b1;
      end else begin
        st[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    st[0] = 1'b0;
    wait_done(0, cyc);
    e = q.pop_front();
    n_vec++;
    if (cyc + 3 !== nn[0]) begin
      n_err++;
      $display("FAIL mid_start_latency got %0d want %0d", cyc + 3, nn[0]);
    end
    n_vec++;
    if (observed(0) !== e) begin
      n_err++;
      $display("FAIL mid_start_result got %h want %h", observed(0), e);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1 || busy_o[0] === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL mid_start_extra got %0d busy/done cycles want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc;
    for (int u = 0; u < 2; u++) begin
      issue(u, 16'h12, 16'h34, 1'b0, 1'b0);
      wait_done(u, cyc);
      e = q.pop_front();
      n_vec++;
      if (observed(u) !== e) begin
        n_err++;
        $display("FAIL b2b_first u=%0d got %h want %h", u, observed(u), e);
      end
      issue(u, 16'h90, 16'hC3, 1'b1, 1'b1);
      n_vec++;
      if (busy_o[u] !== 1'b1 || done_o[u] !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_restart u=%0d got busy=%b done=%b want 1 0", u, busy_o[u], done_o[u]);
      end
      wait_done(u, cyc);
      e = q.pop_front();
      n_vec++;
      if (cyc + 1 !== nn[u] + 1) begin
        n_err++;
        $display("FAIL b2b_spacing u=%0d got %0d want %0d", u, cyc + 1, nn[u] + 1);
      end
      n_vec++;
      if (observed(u) !== e) begin
        n_err++;
        $display("FAIL b2b_second u=%0d got %h want %h", u, observed(u), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int   cyc, pulses;
    issue(0, 16'h77, 16'h19, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    n_vec++;
    if ({busy_o[0], done_o[0], sum_o[0], cout_o[0], ovf_o[0]} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_mid_run got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy_o[0], done_o[0], sum_o[0], cout_o[0], ovf_o[0]);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1 || busy_o[0] === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL reset_abort got %0d busy/done cycles want 0", pulses);
    end
    issue(0, 16'hC8, 16'h64, 1'b1, 1'b0);
    wait_done(0, cyc);
    e = q.pop_front();
    n_vec++;
    if (cyc !== nn[0] || observed(0) !== e) begin
      n_err++;
      $display("FAIL reset_recover got lat=%0d res=%h want lat=%0d res=%h",
               cyc, observed(0), nn[0], e);
    end
  endtask

  task automatic test_random;
    exp_t e;
    int   cyc;
    for (int u = 1; u < 3; u++) begin
      for (int i = 0; i < 20; i++) begin
        issue(u, 16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 2));
        wait_done(u, cyc);
        e = q.pop_front();
        n_vec++;
        if (cyc !== nn[u]) begin
          n_err++;
          $display("FAIL rand_latency u=%0d #%0d got %0d want %0d", u, i, cyc, nn[u]);
        end
        n_vec++;
        if (observed(u) !== e) begin
          n_err++;
          $display("FAIL rand_result u=%0d #%0d got %h want %h", u, i, observed(u), e);
        end
        if ((i % 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
